// File: rtl/led_top_display.sv
// led_top_display
// Drives two 4-digit common-cathode seven-segment displays showing a 32-bit
// value as eight hex digits. Both groups are scanned by one shared index so
// digit K(n) of group 0 and group 1 are lit at the same time.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 synchronous active-high reset (all outputs dark)
//   crtl                0 = display on, 1 = display blanked (scan keeps running)
//   num[31:0]           value to show; num[31:16] on group 0, num[15:0] on group 1
//   LEDx_CA..LEDx_CG    segment a..g of group x, 1 = lit
//   LEDx_DP             decimal point of group x, always 0
//   DNx_K1..DNx_K4      digit selects of group x, K1 leftmost, 1 = selected
module led_top_display #(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        crtl,
    input  logic [31:0] num,
    output logic        LED0_CA,
    output logic        LED0_CB,
    output logic        LED0_CC,
    output logic        LED0_CD,
    output logic        LED0_CE,
    output logic        LED0_CF,
    output logic        LED0_CG,
    output logic        LED0_DP,
    output logic        DN0_K1,
    output logic        DN0_K2,
    output logic        DN0_K3,
    output logic        DN0_K4,
    output logic        LED1_CA,
    output logic        LED1_CB,
    output logic        LED1_CC,
    output logic        LED1_CD,
    output logic        LED1_CE,
    output logic        LED1_CF,
    output logic        LED1_CG,
    output logic        LED1_DP,
    output logic        DN1_K1,
    output logic        DN1_K2,
    output logic        DN1_K3,
    output logic        DN1_K4
);

    localparam int             CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [6:0]    r_seg0, r_seg1;
    logic [3:0]    r_sel0, r_sel1;

    logic          w_wrap;
    logic [3:0]    w_nib0, w_nib1;

    // Segment pattern {a,b,c,d,e,f,g} for one hex nibble.
    function automatic logic [6:0] f_seg(input logic [3:0] n);
        case (n)
            4'h0:    f_seg = 7'b1111110;
            4'h1:    f_seg = 7'b0110000;
            4'h2:    f_seg = 7'b1101101;
            4'h3:    f_seg = 7'b1111001;
            4'h4:    f_seg = 7'b0110011;
            4'h5:    f_seg = 7'b1011011;
            4'h6:    f_seg = 7'b1011111;
            4'h7:    f_seg = 7'b1110000;
            4'h8:    f_seg = 7'b1111111;
            4'h9:    f_seg = 7'b1111011;
            4'hA:    f_seg = 7'b1110111;
            4'hB:    f_seg = 7'b0011111;
            4'hC:    f_seg = 7'b1001110;
            4'hD:    f_seg = 7'b0111101;
            4'hE:    f_seg = 7'b1001111;
            default: f_seg = 7'b1000111;
        endcase
    endfunction

    assign w_wrap = (r_cnt == CNT_MAX);

    // idx 0 selects the leftmost digit, i.e. the most significant nibble.
    always_comb begin
        w_nib0 = num[31:28];
        w_nib1 = num[15:12];
        case (r_idx)
            2'd0: begin w_nib0 = num[31:28]; w_nib1 = num[15:12]; end
            2'd1: begin w_nib0 = num[27:24]; w_nib1 = num[11:8];  end
            2'd2: begin w_nib0 = num[23:20]; w_nib1 = num[7:4];   end
            default: begin w_nib0 = num[19:16]; w_nib1 = num[3:0]; end
        endcase
    end

    // Outputs are built from the pre-update idx, so each digit gets a full
    // CLK_DIV-cycle dwell with selects and segments switching on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_seg0 <= '0;
            r_seg1 <= '0;
            r_sel0 <= '0;
            r_sel1 <= '0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap)
                r_idx <= r_idx + 2'd1;
            if (crtl) begin
                r_seg0 <= '0;
                r_seg1 <= '0;
                r_sel0 <= '0;
                r_sel1 <= '0;
            end else begin
                r_seg0 <= f_seg(w_nib0);
                r_seg1 <= f_seg(w_nib1);
                r_sel0 <= 4'b1000 >> r_idx;
                r_sel1 <= 4'b1000 >> r_idx;
            end
        end
    end

    assign {LED0_CA, LED0_CB, LED0_CC, LED0_CD, LED0_CE, LED0_CF, LED0_CG} = r_seg0;
    assign {LED1_CA, LED1_CB, LED1_CC, LED1_CD, LED1_CE, LED1_CF, LED1_CG} = r_seg1;
    assign {DN0_K1, DN0_K2, DN0_K3, DN0_K4} = r_sel0;
    assign {DN1_K1, DN1_K2, DN1_K3, DN1_K4} = r_sel1;
    assign LED0_DP = 1'b0;
    assign LED1_DP = 1'b0;

endmodule

// File: tb/tb_led_top_display.sv
module tb_led_top_display;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst, crtl;
    logic [31:0] num;
    logic LED0_CA, LED0_CB, LED0_CC, LED0_CD, LED0_CE, LED0_CF, LED0_CG, LED0_DP;
    logic DN0_K1, DN0_K2, DN0_K3, DN0_K4;
    logic LED1_CA, LED1_CB, LED1_CC, LED1_CD, LED1_CE, LED1_CF, LED1_CG, LED1_DP;
    logic DN1_K1, DN1_K2, DN1_K3, DN1_K4;

    always #5 clk = ~clk;

    led_top_display #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .crtl(crtl), .num(num),
        .LED0_CA(LED0_CA), .LED0_CB(LED0_CB), .LED0_CC(LED0_CC), .LED0_CD(LED0_CD),
        .LED0_CE(LED0_CE), .LED0_CF(LED0_CF), .LED0_CG(LED0_CG), .LED0_DP(LED0_DP),
        .DN0_K1(DN0_K1), .DN0_K2(DN0_K2), .DN0_K3(DN0_K3), .DN0_K4(DN0_K4),
        .LED1_CA(LED1_CA), .LED1_CB(LED1_CB), .LED1_CC(LED1_CC), .LED1_CD(LED1_CD),
        .LED1_CE(LED1_CE), .LED1_CF(LED1_CF), .LED1_CG(LED1_CG), .LED1_DP(LED1_DP),
        .DN1_K1(DN1_K1), .DN1_K2(DN1_K2), .DN1_K3(DN1_K3), .DN1_K4(DN1_K4)
    );

    logic [6:0] seg0, seg1;
    logic [3:0] sel0, sel1;
    assign seg0 = {LED0_CA, LED0_CB, LED0_CC, LED0_CD, LED0_CE, LED0_CF, LED0_CG};
    assign seg1 = {LED1_CA, LED1_CB, LED1_CC, LED1_CD, LED1_CE, LED1_CF, LED1_CG};
    assign sel0 = {DN0_K1, DN0_K2, DN0_K3, DN0_K4};
    assign sel1 = {DN1_K1, DN1_K2, DN1_K3, DN1_K4};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Glyph table straight from the segment encoding list.
    logic [6:0] glyph [16];
    initial begin
        glyph[0]  = 7'b1111110; glyph[1]  = 7'b0110000; glyph[2]  = 7'b1101101; glyph[3]  = 7'b1111001;
        glyph[4]  = 7'b0110011; glyph[5]  = 7'b1011011; glyph[6]  = 7'b1011111; glyph[7]  = 7'b1110000;
        glyph[8]  = 7'b1111111; glyph[9]  = 7'b1111011; glyph[10] = 7'b1110111; glyph[11] = 7'b0011111;
        glyph[12] = 7'b1001110; glyph[13] = 7'b0111101; glyph[14] = 7'b1001111; glyph[15] = 7'b1000111;
    end

    // The digit on show at the k-th edge after reset (k from 0) is (k / DIV) mod 4.
    int         ticks = 0;
    bit         started = 0;
    bit         m_on = 0;
    logic [23:0] m_exp = '0;

    always @(posedge clk) begin
        int d;
        logic [3:0] n0, n1;
        started = 1;
        if (rst) begin
            ticks = 0;
            m_on  = 0;
            m_exp = '0;
        end else begin
            d = (ticks / DIV) % 4;
            ticks++;
            n0 = 4'((num >> (16 + 4 * (3 - d))) & 32'hF);
            n1 = 4'((num >> (4 * (3 - d))) & 32'hF);
            m_on = !crtl;
            if (crtl)
                m_exp = '0;
            else
                m_exp = {glyph[n0], 1'b0, 4'(1 << (3 - d)), glyph[n1], 1'b0, 4'(1 << (3 - d))};
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("model_all", {seg0, LED0_DP, sel0, seg1, LED1_DP, sel1}, m_exp);
            if (m_on) begin
                chk("onehot0", $countones(sel0), 1);
                chk("onehot1", $countones(sel1), 1);
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    int m = 0;  // negedges since the first post-reset edge
    task automatic nxt();
        @(negedge clk);
        m++;
    endtask

    task automatic chk_lit(input string nm, input logic [3:0] s0, input logic [6:0] g0,
                           input logic [3:0] s1, input logic [6:0] g1);
        chk({nm, "_sel0"}, sel0, s0);
        chk({nm, "_seg0"}, seg0, g0);
        chk({nm, "_sel1"}, sel1, s1);
        chk({nm, "_seg1"}, seg1, g1);
    endtask

    logic [6:0] lit0 [4];
    logic [6:0] lit1 [4];
    logic [3:0] ksel [4];

    initial begin
        ksel[0] = 4'b1000; ksel[1] = 4'b0100; ksel[2] = 4'b0010; ksel[3] = 4'b0001;
        // group 0 "1 2 3 4", group 1 "5 6 7 8"
        lit0[0] = 7'b0110000; lit0[1] = 7'b1101101; lit0[2] = 7'b1111001; lit0[3] = 7'b0110011;
        lit1[0] = 7'b1011011; lit1[1] = 7'b1011111; lit1[2] = 7'b1110000; lit1[3] = 7'b1111111;

        rst = 1'b1; crtl = 1'b0; num = 32'h12345678;
        // 1. reset holds everything dark
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dark", {seg0, LED0_DP, sel0, seg1, LED1_DP, sel1}, 24'h0);
        rst = 1'b0;
        m = 0;

        // 1+2. first digit, dwell, full frame and wrap
        for (int i = 1; i <= 17; i++) begin
            nxt();
            chk_lit("frame", ksel[((m - 1) / 4) % 4], lit0[((m - 1) / 4) % 4],
                    ksel[((m - 1) / 4) % 4], lit1[((m - 1) / 4) % 4]);
        end

        // 3. hex glyphs; new value visible from edge 18
        num = 32'h89ABCDEF;
        while (m < 20) nxt();
        chk_lit("hex_k1", 4'b1000, 7'b1111111, 4'b1000, 7'b1001110);
        while (m < 24) nxt();
        chk_lit("hex_k2", 4'b0100, 7'b1111011, 4'b0100, 7'b0111101);
        while (m < 28) nxt();
        chk_lit("hex_k3", 4'b0010, 7'b1110111, 4'b0010, 7'b1001111);
        while (m < 32) nxt();
        chk_lit("hex_k4", 4'b0001, 7'b0011111, 4'b0001, 7'b1000111);
        chk("dp", {LED0_DP, LED1_DP}, 2'b00);

        // 4. blank mid-digit, counter keeps running
        while (m < 34) nxt();
        crtl = 1'b1;
        nxt();
        chk("blank", {seg0, LED0_DP, sel0, seg1, LED1_DP, sel1}, 24'h0);
        while (m < 40) nxt();
        crtl = 1'b0;
        nxt();  // m = 41 -> digit K3
        chk_lit("resume", 4'b0010, 7'b1110111, 4'b0010, 7'b1001111);

        // 5. live update while K1 selected
        while (m < 44) nxt();
        num = 32'h00000000;
        while (m < 49) nxt();
        chk_lit("live_pre", 4'b1000, 7'b1111110, 4'b1000, 7'b1111110);
        num = 32'hF0000000;
        nxt();
        chk_lit("live_post", 4'b1000, 7'b1000111, 4'b1000, 7'b1111110);

        // 6. reset at idx=2, cnt=3 (after edge 59) with display blanked
        while (m < 58) nxt();
        crtl = 1'b1;
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_dark", {seg0, LED0_DP, sel0, seg1, LED1_DP, sel1}, 24'h0);
        rst = 1'b0;
        crtl = 1'b0;
        m = 0;
        for (int i = 1; i <= 5; i++) begin
            nxt();
            if (m <= 4)
                chk_lit("restart_k1", 4'b1000, 7'b1000111, 4'b1000, 7'b1111110);
            else
                chk_lit("restart_k2", 4'b0100, 7'b1111110, 4'b0100, 7'b1111110);
        end

        repeat (4) nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
